// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_pkg
// Description : Shared types and constants for the LC-3 memory responder.
// Revision    : 1.0  initial release
// ============================================================================
package lc3_mem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Memory-mapped I/O word: switches on read, hex display on write
    localparam logic [15:0] IO_HEX_SW_ADDR = 16'hFFFF;

    // Wait-state counter width (supports 0..15 wait states)
    localparam int CNT_W = 4;

endpackage : lc3_mem_pkg
`default_nettype wire

// File: rtl/sync_ram16.sv
`default_nettype none
// ============================================================================
// Module      : sync_ram16
// Description : 16-bit wide word RAM, synchronous write, combinational read.
//               No reset: contents survive a system reset.
// Revision    : 1.0  initial release
// ============================================================================
module sync_ram16 #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [2**ADDR_W];

    // Write port: commit on the rising edge when enabled
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule : sync_ram16
`default_nettype wire

// File: rtl/lc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_responder
// Description : Memory-side responder for the LC-3 CPU. Captures a request,
//               waits WAIT_STATES cycles, performs the RAM or I/O access and
//               pulses MEM_R for one cycle.
// Revision    : 1.0  initial release
// ============================================================================
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] SWITCHES,
    output logic [15:0] DATA_TO_CPU,
    output logic        MEM_R,
    output logic        BUSY,
    output logic [15:0] HEX_OUT
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

    mem_state_t       state;
    mem_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      cap_addr;
    logic [15:0]      cap_data;
    logic             cap_we;

    logic             capture;
    logic             access;
    logic             is_io;
    logic             in_ram;
    logic             ram_we;
    logic [15:0]      ram_rdata;

    // Request accepted only when idle; access edge is the last WAIT cycle
    assign capture = (state == IDLE) && MEM_REQ;
    assign access  = (state == WAIT) && (cnt == '0);

    // Decode of the captured address (I/O word takes priority over RAM range)
    assign is_io   = (cap_addr == IO_HEX_SW_ADDR);
    assign in_ram  = ((cap_addr >> ADDR_W) == 16'd0) && !is_io;
    assign ram_we  = access && cap_we && in_ram;

    // MEM_R is high exactly for the single DONE cycle
    assign MEM_R   = (state == DONE);
    assign BUSY    = (state != IDLE);

    sync_ram16 #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .Clk   (Clk),
        .we    (ram_we),
        .addr  (cap_addr[ADDR_W-1:0]),
        .wdata (cap_data),
        .rdata (ram_rdata)
    );

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (MEM_REQ)    state_next = WAIT;
            WAIT:    if (cnt == '0)  state_next = DONE;
            DONE:                    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Capture registers and wait counter
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt      <= '0;
            cap_addr <= 16'h0000;
            cap_data <= 16'h0000;
            cap_we   <= 1'b0;
        end else if (capture) begin
            cnt      <= WAIT_INIT;
            cap_addr <= MAR;
            cap_data <= MDR;
            cap_we   <= MEM_WE;
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt      <= cnt - 1'b1;
        end
    end

    // Access-edge results: read data to the CPU and the hex display register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            DATA_TO_CPU <= 16'h0000;
            HEX_OUT     <= 16'h0000;
        end else if (access) begin
            if (cap_we) begin
                if (is_io) begin
                    HEX_OUT <= cap_data;
                end
            end else if (is_io) begin
                DATA_TO_CPU <= SWITCHES;
            end else if (in_ram) begin
                DATA_TO_CPU <= ram_rdata;
            end else begin
                DATA_TO_CPU <= 16'h0000;
            end
        end
    end

endmodule : lc3_mem_responder
`default_nettype wire

// File: tb/tb_lc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_mem_responder
// Description : Self-checking bench for lc3_mem_responder (WAIT_STATES=2 and 0).
// Revision    : 1.0  initial release
// ============================================================================
module tb_lc3_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [15:0] mar = 16'h0000;
    logic [15:0] mdr = 16'h0000;
    logic [15:0] sw  = 16'h0000;
    logic [15:0] data_out;
    logic        mem_r;
    logic        busy;
    logic [15:0] hex;

    logic        req0 = 1'b0;
    logic        we0  = 1'b0;
    logic [15:0] mar0 = 16'h0000;
    logic [15:0] mdr0 = 16'h0000;
    logic [15:0] data0;
    logic        mem_r0;
    logic        busy0;
    logic [15:0] hex0;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    lc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(2)) u_dut (
        .Clk(clk), .Reset(rst), .MEM_REQ(req), .MEM_WE(we), .MAR(mar), .MDR(mdr),
        .SWITCHES(sw), .DATA_TO_CPU(data_out), .MEM_R(mem_r), .BUSY(busy), .HEX_OUT(hex)
    );

    lc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
        .Clk(clk), .Reset(rst), .MEM_REQ(req0), .MEM_WE(we0), .MAR(mar0), .MDR(mdr0),
        .SWITCHES(sw), .DATA_TO_CPU(data0), .MEM_R(mem_r0), .BUSY(busy0), .HEX_OUT(hex0)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] sw;
        logic [15:0] exp_data;
        logic [15:0] exp_hex;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Issue one request, perturb MAR/MDR after capture, wait for MEM_R (bounded)
    task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int lat);
        @(negedge clk);
        req = 1'b1; we = w; mar = a; mdr = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; mar = ~a; mdr = ~d;
        check("busy_after_capture", {31'd0, busy}, 32'd1);
        lat = -1;
        for (int j = 1; j <= 12; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_r) begin
                lat = j;
                break;
            end
        end
        rd = data_out;
        @(posedge clk);
        @(negedge clk);
        check("mem_r_one_cycle", {31'd0, mem_r}, 32'd0);
    endtask

    initial begin
        logic [15:0] rd;
        int          lat;
        int          seen_r;
        logic [8:0]  pat;

        vecs[0]  = '{1'b1, 16'h0005, 16'h1234, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h1234, 16'h0000};
        vecs[2]  = '{1'b1, 16'h0000, 16'hA5A5, 16'h0000, 16'h1234, 16'h0000};
        vecs[3]  = '{1'b1, 16'h03FF, 16'h7777, 16'h0000, 16'h1234, 16'h0000};
        vecs[4]  = '{1'b0, 16'hFFFF, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000};
        vecs[5]  = '{1'b1, 16'hFFFF, 16'h00AB, 16'hBEEF, 16'hBEEF, 16'h00AB};
        vecs[6]  = '{1'b0, 16'h03FF, 16'h0000, 16'h0000, 16'h7777, 16'h00AB};
        vecs[7]  = '{1'b0, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h00AB};
        vecs[8]  = '{1'b1, 16'h0400, 16'hFFFF, 16'h0000, 16'h0000, 16'h00AB};
        vecs[9]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hA5A5, 16'h00AB};
        vecs[10] = '{1'b1, 16'h0007, 16'h0001, 16'h0000, 16'hA5A5, 16'h00AB};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_data", {16'd0, data_out}, 32'd0);
        check("reset_mem_r", {31'd0, mem_r}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hex", {16'd0, hex}, 32'd0);

        // Table-driven request sequence
        for (int i = 0; i < 11; i++) begin
            sw = vecs[i].sw;
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, lat);
            check($sformatf("v%0d_latency", i), lat, 32'd3);
            check($sformatf("v%0d_data", i), {16'd0, rd}, {16'd0, vecs[i].exp_data});
            check($sformatf("v%0d_hex", i), {16'd0, hex}, {16'd0, vecs[i].exp_hex});
        end

        // Request while busy is ignored
        @(negedge clk);
        req = 1'b1; we = 1'b0; mar = 16'h0005; mdr = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        we = 1'b1; mar = 16'h0005; mdr = 16'h5555;
        seen_r = 0;
        for (int j = 1; j <= 3; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_r) seen_r = j;
        end
        check("busy_read_pulse_at", seen_r, 32'd3);
        check("busy_read_data", {16'd0, data_out}, 32'h1234);
        @(posedge clk);
        @(negedge clk);
        check("busy_back_idle", {31'd0, busy}, 32'd0);
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("busy_not_captured", {31'd0, busy}, 32'd0);
        do_req(1'b0, 16'h0005, 16'h0000, rd, lat);
        check("busy_reread", {16'd0, rd}, 32'h1234);

        // Reset during WAIT aborts the write
        @(negedge clk);
        req = 1'b1; we = 1'b1; mar = 16'h0007; mdr = 16'hDEAD;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_data", {16'd0, data_out}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hex", {16'd0, hex}, 32'd0);
        seen_r = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 2) rst = 1'b0;
            if (mem_r) seen_r++;
        end
        check("abort_no_mem_r", seen_r, 32'd0);
        do_req(1'b0, 16'h0007, 16'h0000, rd, lat);
        check("abort_old_value", {16'd0, rd}, 32'h0001);
        check("abort_latency", lat, 32'd3);

        // Zero wait states: back-to-back requests held continuously
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; mar0 = 16'h0003; mdr0 = 16'h3333;
        pat = '0;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == 1) begin
                we0 = 1'b0;
                mdr0 = 16'h0000;
            end
            pat[j] = mem_r0;
        end
        req0 = 1'b0;
        check("ws0_pulse_pattern", {23'd0, pat}, 32'h124);
        check("ws0_read_data", {16'd0, data0}, 32'h3333);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_lc3_mem_responder
`default_nettype wire
